id_ex_stage_reg: RTL and testbench

//   Parametrised ID/EX pipeline register for the 5-stage CPU. Adds valid tracking,

---
 rtl/id_ex_stage_reg_if.sv | 65 ++++++
 rtl/id_ex_stage_reg.sv | 114 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode-side fields in, registered execute-side copies out.
// slave is the pipeline register itself; master is the decode stage / upstream side.
interface id_ex_stage_reg_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
);
    logic                 Stall_In;
    logic                 Flush_In;
    logic                 Valid_In;
    logic                 RegWrite_In;
    logic                 Mem2Reg_In;
    logic                 MemWrite_In;
    logic                 Branch_In;
    logic                 ALUSrc_In;
    logic                 RegDst_In;
    logic [ALUCTRL_W-1:0] ALUCtrl_In;
    logic [DATA_W-1:0]    RegData1_In;
    logic [DATA_W-1:0]    RegData2_In;
    logic [DATA_W-1:0]    Imm_In;
    logic [ADDR_W-1:0]    RSAddr_In;
    logic [ADDR_W-1:0]    RTAddr_In;
    logic [ADDR_W-1:0]    RDAddr_In;

    logic                 Valid_Out;
    logic                 RegWrite_Out;
    logic                 Mem2Reg_Out;
    logic                 MemWrite_Out;
    logic                 Branch_Out;
    logic                 ALUSrc_Out;
    logic                 RegDst_Out;
    logic [ALUCTRL_W-1:0] ALUCtrl_Out;
    logic [DATA_W-1:0]    RegData1_Out;
    logic [DATA_W-1:0]    RegData2_Out;
    logic [DATA_W-1:0]    Imm_Out;
    logic [ADDR_W-1:0]    RSAddr_Out;
    logic [ADDR_W-1:0]    RTAddr_Out;
    logic [ADDR_W-1:0]    RDAddr_Out;
    logic [ADDR_W-1:0]    DestAddr_Out;
    logic                 LoadUseStall_Out;
    logic [CNT_W-1:0]     BubbleCnt_Out;

    // Handshake: Valid_In qualifies the ID instruction; the stage takes it on an edge
    // unless Stall_In is high or LoadUseStall_Out is high, in which case ID must hold it.
    modport slave (
        input  Stall_In, Flush_In, Valid_In, RegWrite_In, Mem2Reg_In, MemWrite_In,
               Branch_In, ALUSrc_In, RegDst_In, ALUCtrl_In, RegData1_In, RegData2_In,
               Imm_In, RSAddr_In, RTAddr_In, RDAddr_In,
        output Valid_Out, RegWrite_Out, Mem2Reg_Out, MemWrite_Out, Branch_Out,
               ALUSrc_Out, RegDst_Out, ALUCtrl_Out, RegData1_Out, RegData2_Out,
               Imm_Out, RSAddr_Out, RTAddr_Out, RDAddr_Out, DestAddr_Out,
               LoadUseStall_Out, BubbleCnt_Out
    );

    modport master (
        output Stall_In, Flush_In, Valid_In, RegWrite_In, Mem2Reg_In, MemWrite_In,
               Branch_In, ALUSrc_In, RegDst_In, ALUCtrl_In, RegData1_In, RegData2_In,
               Imm_In, RSAddr_In, RTAddr_In, RDAddr_In,
        input  Valid_Out, RegWrite_Out, Mem2Reg_Out, MemWrite_Out, Branch_Out,
               ALUSrc_Out, RegDst_Out, ALUCtrl_Out, RegData1_Out, RegData2_Out,
               Imm_Out, RSAddr_Out, RTAddr_Out, RDAddr_Out, DestAddr_Out,
               LoadUseStall_Out, BubbleCnt_Out
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush/stall priority, load-use bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 16
) (
    input logic              CLOCK,
    input logic              RESET_N,
    id_ex_stage_reg_if.slave bus
);
    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem2reg;
        logic                 mem_write;
        logic                 branch;
        logic                 alu_src;
        logic                 reg_dst;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [DATA_W-1:0]    data1;
        logic [DATA_W-1:0]    data2;
        logic [DATA_W-1:0]    imm;
        logic [ADDR_W-1:0]    rs;
        logic [ADDR_W-1:0]    rt;
        logic [ADDR_W-1:0]    rd;
        logic [ADDR_W-1:0]    dest;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    // A bubble kills side effects only; data and address fields keep their old value.
    function automatic stage_t bubble(input stage_t s);
        stage_t b;
        b           = s;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem2reg   = 1'b0;
        b.mem_write = 1'b0;
        b.branch    = 1'b0;
        b.alu_ctrl  = '0;
        return b;
    endfunction

    // rt only matters when the consumer reads it as a register (R-type) or stores it.
    always_comb begin
        hazard = stage_q.valid & stage_q.mem2reg & bus.Valid_In & ~bus.Flush_In
               & (stage_q.dest != '0)
               & ((stage_q.dest == bus.RSAddr_In)
                  | ((stage_q.dest == bus.RTAddr_In) & (~bus.ALUSrc_In | bus.MemWrite_In)));
    end

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (bus.Flush_In) begin
            stage_d = bubble(stage_q);
        end else if (!bus.Stall_In) begin
            if (hazard) begin
                stage_d = bubble(stage_q);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                stage_d.valid     = bus.Valid_In;
                stage_d.reg_write = bus.Valid_In & bus.RegWrite_In;
                stage_d.mem2reg   = bus.Valid_In & bus.Mem2Reg_In;
                stage_d.mem_write = bus.Valid_In & bus.MemWrite_In;
                stage_d.branch    = bus.Valid_In & bus.Branch_In;
                stage_d.alu_src   = bus.Valid_In & bus.ALUSrc_In;
                stage_d.reg_dst   = bus.Valid_In & bus.RegDst_In;
                stage_d.alu_ctrl  = bus.Valid_In ? bus.ALUCtrl_In : '0;
                stage_d.data1     = bus.RegData1_In;
                stage_d.data2     = bus.RegData2_In;
                stage_d.imm       = bus.Imm_In;
                stage_d.rs        = bus.RSAddr_In;
                stage_d.rt        = bus.RTAddr_In;
                stage_d.rd        = bus.RDAddr_In;
                stage_d.dest      = bus.RegDst_In ? bus.RDAddr_In : bus.RTAddr_In;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Valid_Out        = stage_q.valid;
    assign bus.RegWrite_Out     = stage_q.reg_write;
    assign bus.Mem2Reg_Out      = stage_q.mem2reg;
    assign bus.MemWrite_Out     = stage_q.mem_write;
    assign bus.Branch_Out       = stage_q.branch;
    assign bus.ALUSrc_Out       = stage_q.alu_src;
    assign bus.RegDst_Out       = stage_q.reg_dst;
    assign bus.ALUCtrl_Out      = stage_q.alu_ctrl;
    assign bus.RegData1_Out     = stage_q.data1;
    assign bus.RegData2_Out     = stage_q.data2;
    assign bus.Imm_Out          = stage_q.imm;
    assign bus.RSAddr_Out       = stage_q.rs;
    assign bus.RTAddr_Out       = stage_q.rt;
    assign bus.RDAddr_Out       = stage_q.rd;
    assign bus.DestAddr_Out     = stage_q.dest;
    assign bus.LoadUseStall_Out = hazard;
    assign bus.BubbleCnt_Out    = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a wide-counter instance and a 2-bit-counter
// instance share stimulus; a monitor pops hand-computed expectations per cycle.
module tb_id_ex_stage_reg;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic mon_busy = 1'b0;

  typedef struct packed {
    logic        hz;
    logic        v;
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] d1;
    logic [15:0] cnt;
    logic [1:0]  cnts;
  } exp_t;
  exp_t exp_q[$];

  id_ex_stage_reg_if #(.CNT_W(16)) bus ();
  id_ex_stage_reg_if #(.CNT_W(2))  bus_s ();

  id_ex_stage_reg #(.CNT_W(16)) u_dut   (.CLOCK(clk), .RESET_N(rst_n), .bus(bus));
  id_ex_stage_reg #(.CNT_W(2))  u_dut_s (.CLOCK(clk), .RESET_N(rst_n), .bus(bus_s));

  assign bus_s.Stall_In    = bus.Stall_In;
  assign bus_s.Flush_In    = bus.Flush_In;
  assign bus_s.Valid_In    = bus.Valid_In;
  assign bus_s.RegWrite_In = bus.RegWrite_In;
  assign bus_s.Mem2Reg_In  = bus.Mem2Reg_In;
  assign bus_s.MemWrite_In = bus.MemWrite_In;
  assign bus_s.Branch_In   = bus.Branch_In;
  assign bus_s.ALUSrc_In   = bus.ALUSrc_In;
  assign bus_s.RegDst_In   = bus.RegDst_In;
  assign bus_s.ALUCtrl_In  = bus.ALUCtrl_In;
  assign bus_s.RegData1_In = bus.RegData1_In;
  assign bus_s.RegData2_In = bus.RegData2_In;
  assign bus_s.Imm_In      = bus.Imm_In;
  assign bus_s.RSAddr_In   = bus.RSAddr_In;
  assign bus_s.RTAddr_In   = bus.RTAddr_In;
  assign bus_s.RDAddr_In   = bus.RDAddr_In;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic st, input logic fl, input logic v, input logic rw,
                        input logic m2r, input logic mw, input logic asrc, input logic rdst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] d1);
    bus.Stall_In    = st;
    bus.Flush_In    = fl;
    bus.Valid_In    = v;
    bus.RegWrite_In = rw;
    bus.Mem2Reg_In  = m2r;
    bus.MemWrite_In = mw;
    bus.Branch_In   = 1'b0;
    bus.ALUSrc_In   = asrc;
    bus.RegDst_In   = rdst;
    bus.ALUCtrl_In  = 4'h2;
    bus.RegData1_In = d1;
    bus.RegData2_In = d1 ^ 32'hFFFF;
    bus.Imm_In      = 32'h4;
    bus.RSAddr_In   = rs;
    bus.RTAddr_In   = rt;
    bus.RDAddr_In   = rd;
  endtask

  task automatic step(input logic st, input logic fl, input logic v, input logic rw,
                      input logic m2r, input logic mw, input logic asrc, input logic rdst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] d1, input logic ehz, input logic ev,
                      input logic erw, input logic em2r, input logic [4:0] edest,
                      input logic [31:0] ed1, input logic [15:0] ecnt, input logic [1:0] ecnts);
    exp_t e;
    @(negedge clk);
    set_in(st, fl, v, rw, m2r, mw, asrc, rdst, rs, rt, rd, d1);
    e = '{hz: ehz, v: ev, rw: erw, m2r: em2r, dest: edest, d1: ed1, cnt: ecnt, cnts: ecnts};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (exp_q.size() != 0 || mon_busy)}, 32'd0);
  endtask

  // scoreboard monitor: stall is combinational before the edge, the rest after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        mon_busy = 1'b1;
        e = exp_q.pop_front();
        chk("load_use_stall", {31'd0, bus.LoadUseStall_Out}, {31'd0, e.hz});
        @(posedge clk);
        #1;
        chk("valid_out",    {31'd0, bus.Valid_Out},    {31'd0, e.v});
        chk("regwrite_out", {31'd0, bus.RegWrite_Out}, {31'd0, e.rw});
        chk("mem2reg_out",  {31'd0, bus.Mem2Reg_Out},  {31'd0, e.m2r});
        chk("dest_addr",    {27'd0, bus.DestAddr_Out}, {27'd0, e.dest});
        chk("regdata1_out", bus.RegData1_Out, e.d1);
        chk("bubble_cnt",   {16'd0, bus.BubbleCnt_Out}, {16'd0, e.cnt});
        chk("bubble_cnt_w2", {30'd0, bus_s.BubbleCnt_Out}, {30'd0, e.cnts});
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [1:0] sat_tab [5];

  initial begin
    sat_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'd0, bus.Valid_Out}, 32'd0);
    chk("reset_cnt",   {16'd0, bus.BubbleCnt_Out}, 32'd0);
    chk("reset_stall", {31'd0, bus.LoadUseStall_Out}, 32'd0);
    rst_n = 1'b1;

    // pass-through, load-use, false-hazard cases, store hazard
    step(0,0, 1,1,0,0,0,1, 5'd1,5'd2,5'd3, 32'h5,   0, 1,1,0, 5'd3, 32'h5,   16'd0, 2'd0);
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd4,5'd0, 32'h100, 0, 1,1,1, 5'd4, 32'h100, 16'd0, 2'd0);
    step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hA,   1, 0,0,0, 5'd4, 32'h100, 16'd1, 2'd1);
    step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hA,   0, 1,1,0, 5'd5, 32'hA,   16'd1, 2'd1);
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd0,5'd0, 32'h20,  0, 1,1,1, 5'd0, 32'h20,  16'd1, 2'd1);
    step(0,0, 1,1,0,0,0,1, 5'd0,5'd0,5'd9, 32'h30,  0, 1,1,0, 5'd9, 32'h30,  16'd1, 2'd1);
    step(0,0, 1,1,1,0,1,0, 5'd2,5'd4,5'd0, 32'h40,  0, 1,1,1, 5'd4, 32'h40,  16'd1, 2'd1);
    step(0,0, 1,1,0,0,1,0, 5'd8,5'd4,5'd7, 32'h50,  0, 1,1,0, 5'd4, 32'h50,  16'd1, 2'd1);
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd6,5'd0, 32'h60,  0, 1,1,1, 5'd6, 32'h60,  16'd1, 2'd1);
    step(0,0, 1,0,0,1,1,0, 5'd2,5'd6,5'd0, 32'h70,  1, 0,0,0, 5'd6, 32'h60,  16'd2, 2'd2);
    step(0,0, 1,0,0,1,1,0, 5'd2,5'd6,5'd0, 32'h70,  0, 1,0,0, 5'd6, 32'h70,  16'd2, 2'd2);

    // flush+stall over a hazard, then a 3-cycle stall with a hazard pending
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd4,5'd0, 32'h80,  0, 1,1,1, 5'd4, 32'h80,  16'd2, 2'd2);
    step(1,1, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hB,   0, 0,0,0, 5'd4, 32'h80,  16'd2, 2'd2);
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd4,5'd0, 32'h90,  0, 1,1,1, 5'd4, 32'h90,  16'd2, 2'd2);
    for (int i = 0; i < 3; i++)
      step(1,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hB, 1, 1,1,1, 5'd4, 32'h90,  16'd2, 2'd2);
    step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hB,   1, 0,0,0, 5'd4, 32'h90,  16'd3, 2'd3);
    step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'hB,   0, 1,1,0, 5'd5, 32'hB,   16'd3, 2'd3);

    // Valid_In=0 captures with controls forced low
    step(0,0, 0,1,1,0,0,0, 5'd0,5'd3,5'd0, 32'hC,   0, 0,0,0, 5'd3, 32'hC,   16'd3, 2'd3);
    step(0,0, 1,1,0,0,0,1, 5'd3,5'd6,5'd5, 32'hD,   0, 1,1,0, 5'd5, 32'hD,   16'd3, 2'd3);
    step(0,0, 1,1,1,0,1,0, 5'd1,5'd4,5'd0, 32'hE,   0, 1,1,1, 5'd4, 32'hE,   16'd3, 2'd3);
    drain();

    // asynchronous reset between edges with a hazard showing
    @(negedge clk);
    set_in(0, 0, 1, 1, 0, 0, 0, 1, 5'd4, 5'd6, 5'd5, 32'hF);
    #3;
    chk("t1_stall_before_reset", {31'd0, bus.LoadUseStall_Out}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_valid",   {31'd0, bus.Valid_Out},    32'd0);
    chk("t1_mem2reg", {31'd0, bus.Mem2Reg_Out},  32'd0);
    chk("t1_regwrite", {31'd0, bus.RegWrite_Out}, 32'd0);
    chk("t1_dest",    {27'd0, bus.DestAddr_Out}, 32'd0);
    chk("t1_data1",   bus.RegData1_Out, 32'd0);
    chk("t1_cnt",     {16'd0, bus.BubbleCnt_Out}, 32'd0);
    chk("t1_cnt_w2",  {30'd0, bus_s.BubbleCnt_Out}, 32'd0);
    chk("t1_stall",   {31'd0, bus.LoadUseStall_Out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // five load-use hazards against fresh counters
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] prev_s;
      prev_s = (k == 1) ? 2'd0 : sat_tab[k-2];
      step(0,0, 1,1,1,0,1,0, 5'd1,5'd4,5'd0, 32'h100 + k, 0, 1,1,1, 5'd4, 32'h100 + k,
           16'(k-1), prev_s);
      step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'h200 + k, 1, 0,0,0, 5'd4, 32'h100 + k,
           16'(k), sat_tab[k-1]);
      step(0,0, 1,1,0,0,0,1, 5'd4,5'd6,5'd5, 32'h200 + k, 0, 1,1,0, 5'd5, 32'h200 + k,
           16'(k), sat_tab[k-1]);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
